// File: rtl/ins_fetch_queue_if.sv
// Fetch-queue bus bundle: cache-side handshake and decode-side slot signals.
// master = cache/decode environment, slave = ins_fetch_queue.
interface ins_fetch_queue_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    // cache side
    logic            INS_CACHE_READY;
    logic [31:0]     INS_CACHE_DATA;
    logic [31:0]     INS_CACHE_PC;
    logic            FETCH_REQ;

    // decode side
    logic            STALL_ENABLE;
    logic            FLUSH;
    logic [31:0]     INSTRUCTION;
    logic [31:0]     PC_OUT;
    logic            INS_VALID;

    // status
    logic [CW-1:0]   COUNT;
    logic            OVERFLOW;

    modport master (
        output INS_CACHE_READY,
        output INS_CACHE_DATA,
        output INS_CACHE_PC,
        output STALL_ENABLE,
        output FLUSH,
        input  FETCH_REQ,
        input  INSTRUCTION,
        input  PC_OUT,
        input  INS_VALID,
        input  COUNT,
        input  OVERFLOW
    );

    modport slave (
        input  INS_CACHE_READY,
        input  INS_CACHE_DATA,
        input  INS_CACHE_PC,
        input  STALL_ENABLE,
        input  FLUSH,
        output FETCH_REQ,
        output INSTRUCTION,
        output PC_OUT,
        output INS_VALID,
        output COUNT,
        output OVERFLOW
    );
endinterface

// File: rtl/ins_fetch_queue.sv
// Instruction fetch queue: DEPTH-entry FIFO between the instruction cache and
// a registered decode output slot (INSTRUCTION / PC_OUT / INS_VALID).
// Optional feature macro: INS_FETCH_QUEUE_BYPASS_EN -- when defined, a word
// arriving while the FIFO is empty and the slot is free (or being consumed)
// is loaded straight into the slot in the same edge, skipping the FIFO.
// Without the macro every word goes through the FIFO (two-edge latency).
module ins_fetch_queue #(
    parameter int          DEPTH = 4,
    parameter logic [31:0] NOP   = 32'h0000_0013
) (
    input  logic               CLK,
    input  logic               RST,
    ins_fetch_queue_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // FIFO storage; deliberately not reset, validity lives in the pointers/count
    logic [31:0]   mem_data [DEPTH];
    logic [31:0]   mem_pc   [DEPTH];

    logic [AW-1:0] wr_ptr_reg,  wr_ptr_next;
    logic [AW-1:0] rd_ptr_reg,  rd_ptr_next;
    logic [CW-1:0] count_reg,   count_next;
    logic          valid_reg,   valid_next;
    logic [31:0]   instr_reg,   instr_next;
    logic [31:0]   pc_reg,      pc_next;
    logic          overflow_reg, overflow_next;

    logic          slot_free;
    logic          pop_cond;
    logic          fetch_req;
    logic          accept;
    logic          bypass_load;
    logic          push;
    logic          pop;

    // Handshake decisions for this cycle. FETCH_REQ ignores FLUSH and READY so
    // the cache sees a stable request that only depends on queue state.
    always_comb begin
        slot_free   = !valid_reg || bus.STALL_ENABLE;
        pop_cond    = (count_reg != '0) && slot_free;
        fetch_req   = (count_reg != CW'(DEPTH)) || pop_cond;
        accept      = bus.INS_CACHE_READY && fetch_req && !bus.FLUSH;
`ifdef INS_FETCH_QUEUE_BYPASS_EN
        bypass_load = accept && (count_reg == '0) && slot_free;
`else
        bypass_load = 1'b0;
`endif
        push        = accept && !bypass_load;
        pop         = pop_cond && !bus.FLUSH;
    end

    // Next state of pointers, occupancy and the sticky overflow flag.
    always_comb begin
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        count_next    = count_reg;
        overflow_next = overflow_reg | (bus.INS_CACHE_READY && !fetch_req);
        if (bus.FLUSH) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push) begin
                wr_ptr_next = wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_next = count_reg + CW'(1);
                2'b01:   count_next = count_reg - CW'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    // Output slot: flush beats FIFO pop, pop beats bypass, otherwise a
    // consumed slot drains to NOP while PC_OUT keeps its last value.
    always_comb begin
        valid_next = valid_reg;
        instr_next = instr_reg;
        pc_next    = pc_reg;
        if (bus.FLUSH) begin
            valid_next = 1'b0;
            instr_next = NOP;
        end else if (pop) begin
            valid_next = 1'b1;
            instr_next = mem_data[rd_ptr_reg];
            pc_next    = mem_pc[rd_ptr_reg];
        end
`ifdef INS_FETCH_QUEUE_BYPASS_EN
        else if (bypass_load) begin
            valid_next = 1'b1;
            instr_next = bus.INS_CACHE_DATA;
            pc_next    = bus.INS_CACHE_PC;
        end
`endif
        else if (bus.STALL_ENABLE) begin
            valid_next = 1'b0;
            instr_next = NOP;
        end
    end

    // FIFO write port; no reset so the array maps onto plain RAM.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_data[wr_ptr_reg] <= bus.INS_CACHE_DATA;
            mem_pc[wr_ptr_reg]   <= bus.INS_CACHE_PC;
        end
    end

    // Control and slot registers with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            valid_reg    <= 1'b0;
            instr_reg    <= NOP;
            pc_reg       <= '0;
            overflow_reg <= 1'b0;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            valid_reg    <= valid_next;
            instr_reg    <= instr_next;
            pc_reg       <= pc_next;
            overflow_reg <= overflow_next;
        end
    end

    assign bus.FETCH_REQ   = fetch_req;
    assign bus.INSTRUCTION = instr_reg;
    assign bus.PC_OUT      = pc_reg;
    assign bus.INS_VALID   = valid_reg;
    assign bus.COUNT       = count_reg;
    assign bus.OVERFLOW    = overflow_reg;
endmodule

// File: tb/tb_ins_fetch_queue.sv
// Self-checking bench for ins_fetch_queue: directed scenarios followed by
// random traffic, all compared against a queue-based reference model.
module tb_ins_fetch_queue;
    localparam int          DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;
`ifdef INS_FETCH_QUEUE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic CLK;
    logic RST;

    ins_fetch_queue_if #(.DEPTH(DEPTH)) bus ();

    ins_fetch_queue #(.DEPTH(DEPTH), .NOP(NOP)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int checks   = 0;
    int failures = 0;

    // reference model state: FIFO as a queue of {data, pc}, plus the slot
    logic [63:0] q [$];
    logic        m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_pc;
    logic        m_ovf;

    // scoreboard for the ordering scenario
    bit          rec_en = 1'b0;
    logic [63:0] got [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_valid = 1'b0;
        m_instr = NOP;
        m_pc    = '0;
        m_ovf   = 1'b0;
    endtask

    function automatic bit model_req(input bit st);
        return (q.size() < DEPTH) || (q.size() > 0 && (!m_valid || st));
    endfunction

    task automatic model_edge(input bit rdy, input logic [31:0] d, input logic [31:0] p,
                              input bit st, input bit fl);
        bit req;
        bit free;
        bit acc;
        bit byp;
        req  = model_req(st);
        free = !m_valid || st;
        acc  = rdy && req && !fl;
        byp  = 1'b0;
        if (rdy && !req) m_ovf = 1'b1;
        if (fl) begin
            q.delete();
            m_valid = 1'b0;
            m_instr = NOP;
        end else begin
            if (q.size() > 0 && free) begin
                {m_instr, m_pc} = q.pop_front();
                m_valid = 1'b1;
            end else if (BYPASS && acc && q.size() == 0 && free) begin
                m_instr = d;
                m_pc    = p;
                m_valid = 1'b1;
                byp     = 1'b1;
            end else if (st) begin
                m_valid = 1'b0;
                m_instr = NOP;
            end
            if (acc && !byp) q.push_back({d, p});
        end
    endtask

    // One clock: drive, check the request, clock, update model, check outputs.
    task automatic step(input bit rdy, input logic [31:0] d, input logic [31:0] p,
                        input bit st, input bit fl);
        bus.INS_CACHE_READY = rdy;
        bus.INS_CACHE_DATA  = d;
        bus.INS_CACHE_PC    = p;
        bus.STALL_ENABLE    = st;
        bus.FLUSH           = fl;
        #1;
        check("fetch_req", {31'd0, bus.FETCH_REQ}, {31'd0, model_req(st)});
        if (rec_en && bus.INS_VALID && st && !fl) got.push_back({bus.INSTRUCTION, bus.PC_OUT});
        @(posedge CLK);
        model_edge(rdy, d, p, st, fl);
        #1;
        check("ins_valid",   {31'd0, bus.INS_VALID}, {31'd0, m_valid});
        check("instruction", bus.INSTRUCTION, m_instr);
        check("pc_out",      bus.PC_OUT, m_pc);
        check("count",       32'(bus.COUNT), 32'(q.size()));
        check("overflow",    {31'd0, bus.OVERFLOW}, {31'd0, m_ovf});
        $display("step rdy=%0d st=%0d fl=%0d data=%08h -> valid=%0d instr=%08h pc=%08h count=%0d ovf=%0d",
                 rdy, st, fl, d, bus.INS_VALID, bus.INSTRUCTION, bus.PC_OUT, bus.COUNT, bus.OVERFLOW);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_valid"},     {31'd0, bus.INS_VALID}, 32'd0);
        check({tag, "_instr"},     bus.INSTRUCTION, NOP);
        check({tag, "_pc"},        bus.PC_OUT, 32'd0);
        check({tag, "_count"},     32'(bus.COUNT), 32'd0);
        check({tag, "_overflow"},  {31'd0, bus.OVERFLOW}, 32'd0);
        check({tag, "_fetch_req"}, {31'd0, bus.FETCH_REQ}, 32'd1);
    endtask

    initial begin
        int n;
        bit st;
        bit rdy;

        RST = 1'b0;
        bus.INS_CACHE_READY = 1'b0;
        bus.INS_CACHE_DATA  = '0;
        bus.INS_CACHE_PC    = '0;
        bus.STALL_ENABLE    = 1'b0;
        bus.FLUSH           = 1'b0;
        model_reset();
        #12;
        check_reset_values("reset");
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK);
        #1;

        // single word, decode consuming
        step(1'b1, 32'h0050_0093, 32'h100, 1'b1, 1'b0);
        if (BYPASS) check("single_e1_instr", bus.INSTRUCTION, 32'h0050_0093);
        else        check("single_e1_valid", {31'd0, bus.INS_VALID}, 32'd0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        if (BYPASS) check("single_e2_instr", bus.INSTRUCTION, NOP);
        else        check("single_e2_instr", bus.INSTRUCTION, 32'h0050_0093);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        check("single_e3_instr", bus.INSTRUCTION, NOP);

        // fill to DEPTH with decode holding, then simultaneous push and pop
        for (int k = 0; k < 5; k++) step(1'b1, 32'h1100_0000 + k, 32'h400 + 4 * k, 1'b0, 1'b0);
        check("full_count", 32'(bus.COUNT), 32'd4);
        check("full_fetch_req", {31'd0, bus.FETCH_REQ}, 32'd0);
        step(1'b1, 32'h1100_0005, 32'h414, 1'b1, 1'b0);
        check("pushpop_count", 32'(bus.COUNT), 32'd4);
        check("pushpop_overflow", {31'd0, bus.OVERFLOW}, 32'd0);
        check("pushpop_instr", bus.INSTRUCTION, 32'h1100_0001);
        for (int k = 0; k < 7; k++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // flush with a concurrent push while three words are queued
        for (int k = 0; k < 4; k++) step(1'b1, 32'h2200_0000 + k, 32'h500 + 4 * k, 1'b0, 1'b0);
        check("preflush_count", 32'(bus.COUNT), 32'd3);
        step(1'b1, 32'hDEAD_BEEF, 32'h999, 1'b0, 1'b1);
        check("flush_count", 32'(bus.COUNT), 32'd0);
        check("flush_valid", {31'd0, bus.INS_VALID}, 32'd0);
        check("flush_instr", bus.INSTRUCTION, 32'h0000_0013);
        for (int k = 0; k < 4; k++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        check("postflush_valid", {31'd0, bus.INS_VALID}, 32'd0);

        // overflow: sixth word with decode holding
        for (int k = 0; k < 5; k++) step(1'b1, 32'h3300_0000 + k, 32'h600 + 4 * k, 1'b0, 1'b0);
        check("ovf_fetch_req", {31'd0, bus.FETCH_REQ}, 32'd0);
        step(1'b1, 32'h3300_0005, 32'h614, 1'b0, 1'b0);
        check("ovf_flag", {31'd0, bus.OVERFLOW}, 32'd1);
        check("ovf_count", 32'(bus.COUNT), 32'd4);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

        // ten words, alternating consume, ordering across pointer wrap
        got.delete();
        rec_en = 1'b1;
        n = 0;
        for (int i = 0; i < 60 && n < 10; i++) begin
            st  = i[0];
            rdy = model_req(st);
            step(rdy, 32'hA000_0000 + n, 32'h200 + 4 * n, st, 1'b0);
            if (rdy) n++;
        end
        for (int k = 0; k < 12; k++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        rec_en = 1'b0;
        check("order_len", 32'(got.size()), 32'd10);
        for (int k = 0; k < 10 && k < got.size(); k++) begin
            check("order_data", got[k][63:32], 32'hA000_0000 + k);
            check("order_pc",   got[k][31:0],  32'h200 + 4 * k);
        end

        // asynchronous reset in the middle of traffic
        for (int k = 0; k < 3; k++) step(1'b1, 32'h4400_0000 + k, 32'h700 + 4 * k, 1'b0, 1'b0);
        check("prerst_count", 32'(bus.COUNT), 32'd2);
        bus.INS_CACHE_READY = 1'b0;
        #2;
        RST = 1'b0;
        #1;
        check_reset_values("async_reset");
        model_reset();
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK);
        #1;

        // random traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, $urandom, $urandom, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 15) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ins_fetch_queue.md
INS_FETCH_QUEUE -- requirements
Module: ins_fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, FIFO entries (power of two, >=2), excluding the decode output slot.
REQ-002 Parameter NOP, default 32'h0000_0013, word driven on INSTRUCTION when no valid instruction is present.
REQ-003 CLK  input  1  single clock; all state changes on rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-low.
REQ-005 INS_CACHE_READY  input  1  cache delivers INS_CACHE_DATA/INS_CACHE_PC this cycle.
REQ-006 INS_CACHE_DATA  input  32  fetched instruction word.
REQ-007 INS_CACHE_PC  input  32  address of fetched word.
REQ-008 STALL_ENABLE  input  1  1 = decode consumes the current output slot this cycle; 0 = decode holds.
REQ-009 FLUSH  input  1  discard all queued and in-slot instructions.
REQ-010 FETCH_REQ  output  1  queue can accept a word this cycle.
REQ-011 INSTRUCTION  output  32  registered instruction to decode.
REQ-012 PC_OUT  output  32  registered PC of INSTRUCTION.
REQ-013 INS_VALID  output  1  output slot holds a real instruction.
REQ-014 COUNT  output  log2(DEPTH)+1  FIFO occupancy, output slot excluded.
REQ-015 OVERFLOW  output  1  sticky: a word arrived while FETCH_REQ=0.

Function
REQ-016 Push: word written at FIFO write pointer on the edge where INS_CACHE_READY=1, FETCH_REQ=1, FLUSH=0.
REQ-017 Pop: output slot loads from FIFO read pointer when FIFO non-empty and (INS_VALID=0 or STALL_ENABLE=1).
REQ-018 Slot drain: when FIFO empty, no bypass load, and STALL_ENABLE=1, INS_VALID clears and INSTRUCTION becomes NOP, PC_OUT holds its value.
REQ-019 STALL_ENABLE=0 with INS_VALID=1: INSTRUCTION, PC_OUT, INS_VALID held unchanged.
REQ-020 Pointers are log2(DEPTH) bits and wrap modulo DEPTH; COUNT = pushes - pops, range 0..DEPTH.
REQ-021 FETCH_REQ = (COUNT<DEPTH) or (pop this cycle); combinational, no dependence on INS_CACHE_READY.
REQ-022 Push and pop in the same cycle at COUNT=DEPTH: both happen, COUNT stays DEPTH.
REQ-023 INS_CACHE_READY=1 while FETCH_REQ=0: word dropped, OVERFLOW set to 1 until reset.
REQ-024 Latency without bypass: word pushed at edge E is on INSTRUCTION after edge E+1 at the earliest.
REQ-025 FLUSH=1 at an edge: COUNT=0, pointers=0, INS_VALID=0, INSTRUCTION=NOP; concurrent push and pop suppressed; takes priority over all other events.
REQ-026 Word order on INSTRUCTION equals arrival order; no word duplicated or skipped absent FLUSH/overflow.

Reset
REQ-027 RST low asynchronously forces: pointers=0, COUNT=0, INS_VALID=0, INSTRUCTION=NOP, PC_OUT=0, OVERFLOW=0.
REQ-028 FETCH_REQ=1 during and immediately after reset; reset mid-transfer discards all content.
REQ-029 FIFO storage array is not reset; only valid tracking is.

Configuration
REQ-030 Macro INS_FETCH_QUEUE_BYPASS_EN defined: when COUNT=0 and output slot free or being consumed, an accepted word loads directly into the output slot at edge E (latency 1), FIFO untouched.
REQ-031 Macro undefined: every word passes through the FIFO; latency per REQ-024; no bypass path present.

Verification
REQ-032 Reset then single word 32'h0050_0093 PC 0x100, STALL_ENABLE=1 -> INS_VALID=1, INSTRUCTION=32'h0050_0093 two edges later (one edge with bypass), then NOP.
REQ-033 STALL_ENABLE=0, push 5 words with DEPTH=4 -> FETCH_REQ=0 after 4th FIFO word (slot holds 1st), 6th word sets OVERFLOW=1, COUNT=4.
REQ-034 COUNT=4, STALL_ENABLE=1 and INS_CACHE_READY=1 same cycle -> COUNT stays 4, OVERFLOW stays 0, order preserved.
REQ-035 Queue holding 3 words, FLUSH=1 with concurrent push -> next cycle COUNT=0, INS_VALID=0, INSTRUCTION=32'h0000_0013, pushed word never appears.
REQ-036 Push 10 words with alternating STALL_ENABLE -> output sequence equals input sequence across pointer wrap, PC_OUT matches each word.
REQ-037 RST asserted low mid-stream with COUNT=2 -> outputs reset values immediately without clock edge; FETCH_REQ=1.
